// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencing controller.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          WD_W          = 6;
    localparam logic [4:0]  RSTATUS_REG   = 5'd30;
    localparam logic [31:0] MULT_EXC_CODE = 32'd4;
    localparam logic [31:0] DIV_EXC_CODE  = 32'd5;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/md_watchdog.sv
// Cycle counter bounding how long the controller waits for a unit to report ready.
module md_watchdog
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT = 40  // legal range 20..63 so TIMEOUT-1 fits the counter
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/multdiv_controller.sv
// Issues one mult/div op to the iterative units, stalls X until ready or watchdog
// expiry, then emits a single-cycle writeback (redirected to $rstatus on exception).
module multdiv_controller #(
    parameter int          TIMEOUT       = 40,
    parameter logic [4:0]  RSTATUS_REG   = multdiv_pkg::RSTATUS_REG,
    parameter logic [31:0] MULT_EXC_CODE = multdiv_pkg::MULT_EXC_CODE,
    parameter logic [31:0] DIV_EXC_CODE  = multdiv_pkg::DIV_EXC_CODE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        x_valid,
    input  logic        x_is_mult,
    input  logic        x_is_div,
    input  logic [31:0] x_opA,
    input  logic [31:0] x_opB,
    input  logic [4:0]  x_rd,
    input  logic        flush,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    input  logic        md_resultRDY,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy
);

    import multdiv_pkg::*;

    state_t     state, state_nxt;
    logic       op_type;
    logic [4:0] rd_q;
    logic       accept, finish, take_exc, wd_expired;

    md_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == START),
        .en      (state == BUSY),
        .expired (wd_expired)
    );

    // Ready takes precedence over a watchdog expiry landing in the same cycle.
    assign take_exc = md_resultRDY ? md_exception : 1'b1;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        stall     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                // Gated by reset so stall stays low while reset is held.
                accept = x_valid & (x_is_mult | x_is_div) & ~flush & ~reset;
                stall  = accept;
                if (accept) state_nxt = START;
            end
            START: begin
                stall     = 1'b1;
                state_nxt = flush ? IDLE : BUSY;
            end
            BUSY: begin
                stall  = 1'b1;
                finish = ~flush & (md_resultRDY | wd_expired);
                if (flush)       state_nxt = IDLE;
                else if (finish) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ctrl_mult   <= 1'b0;
            ctrl_div    <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            md_operandA <= '0;
            md_operandB <= '0;
            op_type     <= OP_MULT;
            rd_q        <= '0;
        end else begin
            state     <= state_nxt;
            // Both flags high resolves to mult.
            ctrl_mult <= accept & x_is_mult;
            ctrl_div  <= accept & ~x_is_mult;
            wb_valid  <= finish;
            if (accept) begin
                md_operandA <= x_opA;
                md_operandB <= x_opB;
                op_type     <= x_is_mult ? OP_MULT : OP_DIV;
                rd_q        <= x_rd;
            end
            if (finish) begin
                if (take_exc) begin
                    wb_rd   <= RSTATUS_REG;
                    wb_data <= (op_type == OP_DIV) ? DIV_EXC_CODE : MULT_EXC_CODE;
                end else begin
                    wb_rd   <= rd_q;
                    wb_data <= md_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_controller.sv
// Self-checking bench: each op's writeback packet, latency, pulses and stall are
// predicted from the accept cycle and the ready schedule, independent of the RTL.
module tb_multdiv_controller;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        x_valid, x_is_mult, x_is_div, flush;
    logic [31:0] x_opA, x_opB;
    logic [4:0]  x_rd;
    logic [31:0] md_operandA, md_operandB, md_result, wb_data;
    logic        ctrl_mult, ctrl_div, md_resultRDY, md_exception;
    logic        stall, wb_valid, busy;
    logic [4:0]  wb_rd;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multdiv_controller #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .x_valid      (x_valid),
        .x_is_mult    (x_is_mult),
        .x_is_div     (x_is_div),
        .x_opA        (x_opA),
        .x_opB        (x_opB),
        .x_rd         (x_rd),
        .flush        (flush),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .md_resultRDY (md_resultRDY),
        .md_result    (md_result),
        .md_exception (md_exception),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .busy         (busy)
    );

    // One op from accept to the cycle after DONE. rdy_at: BUSY-cycle index at
    // which ready is driven, or -1 for never (watchdog path). Returns positioned
    // at the IDLE cycle right after DONE so calls chain back to back.
    task automatic run_op(input string name, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int rdy_at,
                          input logic [31:0] res, input bit exc, input bit spur_start);
        int          exp_lat, wb_cnt, wb_cyc, pm, pd, pulse_cyc, stall_bad, op_bad;
        bit          exp_exc;
        logic [4:0]  exp_rd, got_rd;
        logic [31:0] exp_data, got_data;
        exp_exc  = (rdy_at < 0) || exc;
        exp_rd   = exp_exc ? 5'd30 : rd;
        exp_data = exp_exc ? (m ? 32'd4 : 32'd5) : res;
        exp_lat  = (rdy_at < 0) ? TIMEOUT + 2 : rdy_at + 3;
        wb_cnt = 0; wb_cyc = -1; pm = 0; pd = 0; pulse_cyc = -1; stall_bad = 0; op_bad = 0;
        got_rd = '0; got_data = '0;

        x_valid = 1'b1; x_is_mult = m; x_is_div = d; x_opA = a; x_opB = b; x_rd = rd;
        #1;
        n_checks++;
        if (stall !== 1'b1) $display("FAIL %s accept_stall: got %b expected 1", name, stall);
        else n_pass++;
        @(posedge clk); #1;
        x_valid = 1'b0;

        for (int c = 1; c <= exp_lat + 1; c++) begin
            if (ctrl_mult === 1'b1) begin pm++; pulse_cyc = c; end
            if (ctrl_div === 1'b1)  begin pd++; pulse_cyc = c; end
            if (wb_valid === 1'b1) begin
                wb_cnt++; wb_cyc = c; got_rd = wb_rd; got_data = wb_data;
            end
            if (stall !== (c < exp_lat)) stall_bad++;
            if (busy !== (c <= exp_lat)) stall_bad++;
            if (c <= exp_lat && (md_operandA !== a || md_operandB !== b)) op_bad++;
            if (c == exp_lat + 1) break;
            x_opA = $urandom; x_opB = $urandom; x_rd = 5'($urandom);
            x_is_mult = 1'($urandom); x_is_div = 1'($urandom);
            md_resultRDY = (rdy_at >= 0 && c == rdy_at + 2) || (spur_start && c == 1);
            md_result    = (rdy_at >= 0 && c == rdy_at + 2) ? res : $urandom;
            md_exception = (rdy_at >= 0 && c == rdy_at + 2) ? exc : 1'($urandom);
            @(posedge clk); #1;
        end
        md_resultRDY = 1'b0; md_exception = 1'b0; x_is_mult = 1'b0; x_is_div = 1'b0;

        n_checks++;
        if (wb_cnt !== 1) $display("FAIL %s wb_count: got %0d expected 1", name, wb_cnt);
        else n_pass++;
        n_checks++;
        if (wb_cyc !== exp_lat) $display("FAIL %s wb_latency: got %0d expected %0d", name, wb_cyc, exp_lat);
        else n_pass++;
        n_checks++;
        if (got_rd !== exp_rd) $display("FAIL %s wb_rd: got %0d expected %0d", name, got_rd, exp_rd);
        else n_pass++;
        n_checks++;
        if (got_data !== exp_data) $display("FAIL %s wb_data: got %0h expected %0h", name, got_data, exp_data);
        else n_pass++;
        n_checks++;
        if (pm !== int'(m) || pd !== int'(!m))
            $display("FAIL %s start_pulses: got mult=%0d div=%0d expected mult=%0d div=%0d", name, pm, pd, m, !m);
        else n_pass++;
        n_checks++;
        if (pulse_cyc !== 1) $display("FAIL %s pulse_cycle: got %0d expected 1", name, pulse_cyc);
        else n_pass++;
        n_checks++;
        if (stall_bad !== 0) $display("FAIL %s stall_busy_profile: got %0d bad cycles expected 0", name, stall_bad);
        else n_pass++;
        n_checks++;
        if (op_bad !== 0) $display("FAIL %s operand_stability: got %0d bad cycles expected 0", name, op_bad);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; md_resultRDY = 1'b0; md_result = '0; md_exception = 1'b0;
        x_valid = 1'b1; x_is_mult = 1'b1; x_is_div = 1'b0; x_opA = 32'd11; x_opB = 32'd12; x_rd = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({stall, busy, wb_valid, ctrl_mult, ctrl_div, wb_rd, wb_data, md_operandA, md_operandB} !== '0)
            $display("FAIL reset_outputs: got stall=%b busy=%b wbv=%b cm=%b cd=%b rd=%0d data=%0h A=%0h B=%0h expected all 0",
                     stall, busy, wb_valid, ctrl_mult, ctrl_div, wb_rd, wb_data, md_operandA, md_operandB);
        else n_pass++;
        x_valid = 1'b0; x_is_mult = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult_basic();
        run_op("mult7x6", 1'b1, 1'b0, 32'd7, 32'd6, 5'd5, 17, 32'd42, 1'b0, 1'b0);
    endtask

    task automatic test_exceptions();
        run_op("mult_exc", 1'b1, 1'b0, 32'h7fffffff, 32'd2, 5'd9, 6, 32'hdead, 1'b1, 1'b0);
        run_op("div_exc", 1'b0, 1'b1, 32'd100, 32'd0, 5'd12, 10, 32'hbeef, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        run_op("div_timeout", 1'b0, 1'b1, 32'd81, 32'd9, 5'd7, -1, 32'd0, 1'b0, 1'b0);
        run_op("mult_timeout", 1'b1, 1'b0, 32'd5, 32'd5, 5'd8, -1, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        int wb_seen;
        wb_seen = 0;
        x_valid = 1'b1; x_is_mult = 1'b1; x_is_div = 1'b0; x_opA = 32'd13; x_opB = 32'd4; x_rd = 5'd6;
        @(posedge clk); #1;
        x_valid = 1'b0; x_is_mult = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL flush_idle: got busy=%b stall=%b wbv=%b expected 0 0 0", busy, stall, wb_valid);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (wb_valid === 1'b1) wb_seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (wb_seen !== 0) $display("FAIL flush_no_wb: got %0d strobes expected 0", wb_seen);
        else n_pass++;
        run_op("after_flush3x3", 1'b1, 1'b0, 32'd3, 32'd3, 5'd10, 4, 32'd9, 1'b0, 1'b0);
    endtask

    task automatic test_spurious();
        int bad;
        bad = 0;
        x_valid = 1'b0;
        md_resultRDY = 1'b1; md_result = 32'h1234; md_exception = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (wb_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        md_resultRDY = 1'b0; md_exception = 1'b0;
        n_checks++;
        if (bad !== 0) $display("FAIL spurious_idle_ready: got %0d bad cycles expected 0", bad);
        else n_pass++;
        run_op("both_flags_spur_start", 1'b1, 1'b1, 32'd21, 32'd2, 5'd14, 5, 32'd42, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int wb_seen;
        wb_seen = 0;
        x_valid = 1'b1; x_is_div = 1'b1; x_is_mult = 1'b0; x_opA = 32'd50; x_opB = 32'd7; x_rd = 5'd2;
        @(posedge clk); #1;
        x_valid = 1'b0; x_is_div = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1; md_resultRDY = 1'b1; md_result = 32'd7;
        @(posedge clk); #1;
        n_checks++;
        if ({stall, busy, wb_valid, ctrl_mult, ctrl_div, wb_rd, wb_data, md_operandA, md_operandB} !== '0)
            $display("FAIL reset_mid_outputs: got stall=%b busy=%b wbv=%b rd=%0d data=%0h A=%0h B=%0h expected all 0",
                     stall, busy, wb_valid, wb_rd, wb_data, md_operandA, md_operandB);
        else n_pass++;
        reset = 1'b0; md_resultRDY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wb_valid === 1'b1 || busy === 1'b1) wb_seen++;
        end
        n_checks++;
        if (wb_seen !== 0) $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", wb_seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first", 1'b1, 1'b0, 32'd12, 32'd12, 5'd17, 0, 32'd144, 1'b0, 1'b0);
        run_op("b2b_second", 1'b1, 1'b0, 32'd9, 32'd8, 5'd18, 2, 32'd72, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        bit          m, exc;
        int          rdy;
        for (int i = 0; i < 8; i++) begin
            a   = $urandom;
            b   = $urandom;
            m   = 1'($urandom);
            exc = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 30));
            run_op($sformatf("rand%0d", i), m, !m, a, b, 5'($urandom), rdy,
                   m ? a * b : a ^ b, exc, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_exceptions();
        test_timeout();
        test_flush();
        test_spurious();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multdiv_controller.md
# multdiv_controller

Sequencing controller between the execute stage and the iterative multiply/divide units. It accepts one mult/div instruction from X, holds the operands stable, and issues a one-cycle start pulse (ctrl_mult or ctrl_div). It stalls the pipeline until the unit reports ready or a watchdog expires, then presents a single-cycle writeback packet with an exception redirect to $rstatus.

## Interface
- TIMEOUT, default 40: cycles in BUSY without ready before a forced exception; legal range 20..63.
- RSTATUS_REG, default 30: destination register on exception.
- MULT_EXC_CODE, default 4; DIV_EXC_CODE, default 5: value written to $rstatus.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- x_valid  in  1  X-stage instruction valid
- x_is_mult  in  1  instruction is mul
- x_is_div  in  1  instruction is div
- x_opA  in  32  multiplicand / dividend
- x_opB  in  32  multiplier / divisor
- x_rd  in  5  destination register
- flush  in  1  kill in-flight op (branch/jump redirect)
- md_operandA  out  32  latched opA, stable from accept until return to IDLE
- md_operandB  out  32  latched opB, same stability
- ctrl_mult  out  1  registered one-cycle start pulse to multiplier
- ctrl_div  out  1  registered one-cycle start pulse to divider
- md_resultRDY  in  1  active unit's result ready
- md_result  in  32  active unit's result
- md_exception  in  1  active unit's exception (overflow / divide-by-zero)
- stall  out  1  hold F/D/X
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- busy  out  1  state != IDLE

## Operation
- States: IDLE, START, BUSY, DONE.
- IDLE:
  - If x_valid & (x_is_mult | x_is_div) & ~flush, latch operands, op type, and rd, then go to START.
  - If x_is_mult and x_is_div are both high, treat the instruction as mult.
- START:
  - Exactly one of ctrl_mult/ctrl_div is high for this cycle only.
  - Clear the watchdog counter, then go to BUSY.
- BUSY:
  - The counter increments each cycle.
  - md_resultRDY high: capture md_result and md_exception, go to DONE.
  - Otherwise, if the counter equals TIMEOUT-1: capture exception=1 and data=0, go to DONE.
- DONE: wb_valid=1 for one cycle, then go to IDLE. No new instruction is accepted in DONE.
- Writeback packet:
  - Exception case: wb_rd=RSTATUS_REG; wb_data=MULT_EXC_CODE (mult) or DIV_EXC_CODE (div).
  - Normal case: wb_rd=latched rd, wb_data=captured result. rd=0 still strobes; the regfile discards it.
- stall = (IDLE & x_valid & (x_is_mult|x_is_div) & ~flush) | START | BUSY. stall is combinational in IDLE so the instruction holds in X. stall is low in DONE so the instruction advances with its writeback.
- flush:
  - In START or BUSY: go to IDLE next cycle, no wb_valid, captured data discarded. The unit's abandoned run is harmless because the next start pulse restarts it.
  - In DONE: ignored; writeback completes.
- md_resultRDY is ignored outside BUSY, including the START cycle.

## Timing
- Reset values:
  - state = IDLE.
  - ctrl_mult, ctrl_div, wb_valid, busy = 0.
  - md_operandA, md_operandB, wb_rd, wb_data = 0.
  - stall follows its equation, which evaluates to 0 while reset is held.
- Reset mid-operation returns to IDLE in one cycle with no writeback.
- Accept at cycle T. The start pulse is high during T+1. The earliest ready sample is T+2.
- Ready seen at cycle Tk puts wb_valid at Tk+1.
- Minimum accept-to-writeback latency: 3 cycles. Timeout writeback occurs at T+2+TIMEOUT.
- Back-to-back: the next mult/div can be accepted the cycle after DONE, so issue interval = latency+1.
- Operands never change while busy=1.

## Structure
- Shared package multdiv_pkg:
  - state encoding (2-bit: IDLE=0, START=1, BUSY=2, DONE=3)
  - RSTATUS_REG, MULT_EXC_CODE, DIV_EXC_CODE constants
  - operation type constant (OP_MULT=0, OP_DIV=1)
- One sub-module, md_watchdog: 6-bit counter with sync clear, enable, and an expired output compared against TIMEOUT-1.

## Test plan
- Mult 7×6, rd=5; ready pulsed after 17 BUSY cycles, result 42 → one wb_valid with rd=5, data=42. stall is high from accept through BUSY and low in DONE. ctrl_mult is high exactly one cycle.
- Mult with exception=1 at ready, rd=9 → wb_rd=30, wb_data=4. Div with exception=1 → wb_rd=30, wb_data=5.
- Div with no ready ever, TIMEOUT=40 → wb_valid at accept+42 with rd=30, data=5. ctrl_div pulsed once.
- flush asserted 5 cycles into BUSY → IDLE next cycle, no wb_valid, stall low. A following mult 3×3 (result 9) completes normally with data 9.
- Spurious md_resultRDY in IDLE and START → ignored. Simultaneous x_is_mult and x_is_div → ctrl_mult pulses, ctrl_div stays 0.
- Reset asserted mid-BUSY → all outputs 0 and state IDLE next cycle. Two back-to-back mults are accepted with a 1-cycle gap after DONE.
